otter_crypto_engine: RTL and testbench

OTTER_CRYPTO_ENGINE -- requirements
Module: otter_crypto_engine

---
 rtl/otter_crypto_engine.sv | 99 +++++++++
 tb/tb_otter_crypto_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/otter_crypto_engine.sv
// Iterated rotate/xor/add block cipher: encrypt or decrypt one operand in ROUNDS cycles.
// Latency: DONE rises ROUNDS+1 edges after START is driven. START is ignored while BUSY or DONE; there is no backpressure.
module otter_crypto_engine #(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 4,
  parameter int ROT    = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              MODE,
  input  logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] KEY,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] DOUT
);
  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     idx;
  logic [DATA_W-1:0] x_q, key_q, round_key, round_out;
  logic              mode_q;
  int unsigned       kshift;

  // Rotations through a doubled word so a zero shift needs no special case.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v, input int unsigned sh);
    logic [2*DATA_W-1:0] t;
    t = {v, v} << sh;
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] v, input int unsigned sh);
    logic [2*DATA_W-1:0] t;
    t = {v, v} >> sh;
    return t[DATA_W-1:0];
  endfunction

  always_comb begin
    idx       = mode_q ? (LAST - cnt) : cnt;
    kshift    = 32'(idx) % 32'(DATA_W);
    round_key = rotl(key_q, kshift);
    if (mode_q)
      round_out = rotr(x_q - round_key, ROT) ^ round_key;
    else
      round_out = rotl(x_q ^ round_key, ROT) + round_key;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (START) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt    <= '0;
      x_q    <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      DOUT   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            x_q    <= DIN;
            key_q  <= KEY;
            mode_q <= MODE;
            cnt    <= '0;
          end
        end
        ST_RUN: begin
          x_q <= round_out;
          // Counter saturates on the final round so it never wraps.
          if (cnt == LAST) DOUT <= round_out;
          else             cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_otter_crypto_engine.sv
// Randomized bench for otter_crypto_engine: transaction-level cipher model plus per-cycle output compare.
`timescale 1ns/1ps
module tb_otter_crypto_engine;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, mode;
  logic [31:0] din, key, dout;
  logic        busy, done;
  logic        s1_start, s1_mode;
  logic [31:0] s1_din, s1_key, s1_dout;
  logic        s1_busy, s1_done;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  otter_crypto_engine #(.DATA_W(32), .ROUNDS(R), .ROT(5)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .MODE(mode), .DIN(din), .KEY(key),
    .BUSY(busy), .DONE(done), .DOUT(dout)
  );

  otter_crypto_engine #(.DATA_W(32), .ROUNDS(1), .ROT(5)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(s1_start), .MODE(s1_mode), .DIN(s1_din), .KEY(s1_key),
    .BUSY(s1_busy), .DONE(s1_done), .DOUT(s1_dout)
  );

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    int m;
    m = s % 32;
    if (m == 0) return v;
    return (v << m) | (v >> (32 - m));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] v, input int s);
    int m;
    m = s % 32;
    if (m == 0) return v;
    return (v >> m) | (v << (32 - m));
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] x, input logic [31:0] k, input int n);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = rl(r ^ rl(k, i), 5) + rl(k, i);
    return r;
  endfunction

  function automatic logic [31:0] dec(input logic [31:0] x, input logic [31:0] k, input int n);
    logic [31:0] r;
    r = x;
    for (int i = n - 1; i >= 0; i--) r = rr(r - rl(k, i), 5) ^ rl(k, i);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Operation-level model: ph 0 idle, 1..R running, R+1 completion pulse.
  int          ph = 0;
  logic [31:0] m_res = '0;
  logic [31:0] exp_dout = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      exp_dout = '0;
    end else if (ph == 0) begin
      if (start) begin
        ph = 1;
        m_res = mode ? dec(din, key, R) : enc(din, key, R);
      end
    end else if (ph < R) begin
      ph++;
    end else if (ph == R) begin
      ph = R + 1;
      exp_dout = m_res;
    end else begin
      ph = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    check("busy", 32'(busy), 32'(ph >= 1 && ph <= R));
    check("done", 32'(done), 32'(ph == R + 1));
    check("dout", dout, exp_dout);
  end

  task automatic run_op(input logic m, input logic [31:0] d, input logic [31:0] k, input bit interfere,
                        output logic [31:0] res, output int edges, output int busy_cyc, output int dones);
    @(negedge clk);
    start = 1'b1; mode = m; din = d; key = k;
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); din = $urandom; key = $urandom;
    edges = 1;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 20) begin
      if (interfere && edges == 2) begin
        start = 1'b1; din = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
      if (busy) busy_cyc++;
    end
    start = 1'b0;
    res = dout;
    dones = done ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  initial begin
    logic [31:0] res, ct, d, k;
    int edges, bc, dn, n;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; din = '0; key = '0;
    s1_start = 1'b0; s1_mode = 1'b0; s1_din = '0; s1_key = '0;

    check("model_enc_pin", enc(32'h1, 32'h0, 4), 32'h0010_0000);
    check("model_dec_pin", dec(32'h0010_0000, 32'h0, 4), 32'h1);
    check("model_r1_pin", enc(32'h1, 32'h0, 1), 32'h0000_0020);

    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_dout_r1", s1_dout, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 32'h1, 32'h0, 1'b0, res, edges, bc, dn);
    check("enc_basic", res, 32'h0010_0000);
    check("enc_latency", 32'(edges), 32'd5);
    check("enc_busy_cycles", 32'(bc), 32'd4);
    check("enc_done_pulses", 32'(dn), 32'd1);

    run_op(1'b1, 32'h0010_0000, 32'h0, 1'b0, res, edges, bc, dn);
    check("dec_basic", res, 32'h1);

    run_op(1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, ct, edges, bc, dn);
    check("rt_enc_model", ct, enc(32'hDEAD_BEEF, 32'h1357_9BDF, R));
    run_op(1'b1, ct, 32'h1357_9BDF, 1'b0, res, edges, bc, dn);
    check("rt_deadbeef", res, 32'hDEAD_BEEF);

    for (int i = 0; i < 1000; i++) begin
      d = $urandom; k = $urandom;
      run_op(1'b0, d, k, 1'b0, ct, edges, bc, dn);
      run_op(1'b1, enc(d, k, R), k, 1'b0, res, edges, bc, dn);
      check("rt_random", res, d);
    end

    d = $urandom; k = $urandom;
    run_op(1'b0, d, k, 1'b1, res, edges, bc, dn);
    check("ignore_start_result", res, enc(d, k, R));
    check("ignore_start_pulses", 32'(dn), 32'd1);

    // Reset during the second RUN cycle.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; din = $urandom; key = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_dout", dout, 32'h0);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    rst_n = 1'b1;
    d = $urandom; k = $urandom;
    run_op(1'b1, d, k, 1'b0, res, edges, bc, dn);
    check("post_reset_op", res, dec(d, k, R));
    check("post_reset_latency", 32'(edges), 32'd5);

    repeat (400) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      mode = 1'($urandom); din = $urandom; key = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Single-round instance: latency and back-to-back spacing with START held.
    @(negedge clk);
    s1_start = 1'b1; s1_mode = 1'b0; s1_din = 32'h1; s1_key = 32'h0;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!s1_done && edges < 20);
    check("r1_latency", 32'(edges), 32'd2);
    check("r1_dout", s1_dout, 32'h0000_0020);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s1_done && n < 20);
    check("r1_spacing", 32'(n), 32'd3);
    check("r1_dout_again", s1_dout, 32'h0000_0020);
    s1_start = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
